// File: rtl/pixel_merge_controller.sv
// Frame sequencer for the 8-to-32 pixel merger: feeds pixels, writes merged words, pads the last word.
// Optional write-stall counter port enabled by defining PIXEL_MERGE_CONTROLLER_STALL_COUNT_EN.
`timescale 1ns/1ps

module pixel_merge_controller #(
  parameter int unsigned PIXEL_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 20,
  parameter int unsigned FRAME_PIXELS  = 307200,
  parameter int unsigned BASE_ADDRESS  = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     frame_start,
  input  logic [PIXEL_WIDTH-1:0]   pixel_in,
  input  logic                     pixel_valid,
  output logic                     pixel_ready,
  output logic [PIXEL_WIDTH-1:0]   merger_pixel,
  output logic                     merger_enable,
  output logic                     merger_reset,
  input  logic [DATA_WIDTH-1:0]    merger_data,
  output logic                     wr_request,
  input  logic                     wr_grant,
  output logic [ADDRESS_WIDTH-1:0] wr_address,
  output logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     busy,
  output logic                     frame_done
`ifdef PIXEL_MERGE_CONTROLLER_STALL_COUNT_EN
  ,
  output logic [15:0]              stall_count
`endif
);

  localparam int unsigned PIXEL_NUMBER = DATA_WIDTH / PIXEL_WIDTH;
  localparam int unsigned LANE_WIDTH   = $clog2(PIXEL_NUMBER);
  localparam int unsigned COUNT_WIDTH  = $clog2(FRAME_PIXELS + 1);
  localparam logic [LANE_WIDTH-1:0]    LAST_LANE  = LANE_WIDTH'(PIXEL_NUMBER - 1);
  localparam logic [COUNT_WIDTH-1:0]   LAST_COUNT = COUNT_WIDTH'(FRAME_PIXELS);
  localparam logic [ADDRESS_WIDTH-1:0] BASE       = ADDRESS_WIDTH'(BASE_ADDRESS);

  typedef enum logic [2:0] {IDLE, RUN, CAPTURE, WRITE, FLUSH, DONE} state_t;

  state_t                 state;
  logic [LANE_WIDTH-1:0]  lane;
  logic [COUNT_WIDTH-1:0] count;
  logic                   transfer;

  // pixel_ready is only ever high in RUN, so a transfer implies RUN
  assign transfer = pixel_valid && pixel_ready;

  always_comb begin
    merger_enable = transfer || (state == FLUSH);
    merger_pixel  = (state == FLUSH) ? '0 : pixel_in;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      pixel_ready  <= 1'b0;
      merger_reset <= 1'b1;
      wr_request   <= 1'b0;
      wr_address   <= BASE;
      wr_data      <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      lane         <= '0;
      count        <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          merger_reset <= 1'b1;
          if (frame_start) begin
            state        <= RUN;
            busy         <= 1'b1;
            pixel_ready  <= 1'b1;
            merger_reset <= 1'b0;
            wr_address   <= BASE;
            lane         <= '0;
            count        <= '0;
          end
        end
        RUN: begin
          if (transfer) begin
            count <= count + COUNT_WIDTH'(1);
            if (lane == LAST_LANE) begin
              lane        <= '0;
              pixel_ready <= 1'b0;
              state       <= CAPTURE;
            end else begin
              lane <= lane + LANE_WIDTH'(1);
              // frame ended mid-word: pad the remaining lanes with zeros
              if (count + COUNT_WIDTH'(1) == LAST_COUNT) begin
                pixel_ready <= 1'b0;
                state       <= FLUSH;
              end
            end
          end
        end
        FLUSH: begin
          if (lane == LAST_LANE) begin
            lane  <= '0;
            state <= CAPTURE;
          end else begin
            lane <= lane + LANE_WIDTH'(1);
          end
        end
        CAPTURE: begin
          wr_data    <= merger_data;
          wr_request <= 1'b1;
          state      <= WRITE;
        end
        WRITE: begin
          if (wr_grant) begin
            wr_request <= 1'b0;
            wr_address <= wr_address + ADDRESS_WIDTH'(1);
            if (count == LAST_COUNT) begin
              state      <= DONE;
              frame_done <= 1'b1;
            end else begin
              state       <= RUN;
              pixel_ready <= 1'b1;
            end
          end
        end
        DONE: begin
          state        <= IDLE;
          busy         <= 1'b0;
          merger_reset <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PIXEL_MERGE_CONTROLLER_STALL_COUNT_EN
  // saturating count of cycles a write request waits for a grant
  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (state == IDLE && frame_start) begin
      stall_count <= '0;
    end else if (wr_request && !wr_grant && stall_count != 16'hFFFF) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule
